project1_buttons_irq: RTL

//  Parametrised Avalon-MM input PIO. Successor to the fixed 3-bit button port.

---
 rtl/project1_buttons_irq.sv | 119 +++++++++++
 1 files changed

// File: rtl/project1_buttons_irq.sv
// Avalon-MM input PIO: synchronises and optionally debounces WIDTH inputs,
// latches selected edges into a W1C capture register and raises a maskable irq.
module project1_buttons_irq #(
    parameter int unsigned WIDTH           = 3,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 0,
    parameter int unsigned EDGE_TYPE       = 0,
    parameter int unsigned IRQ_TYPE        = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] prev;
    logic [WIDTH-1:0] irq_mask;
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] edge_evt;
    logic [WIDTH-1:0] w1c;
    logic             wr_en;
    logic             unused_wd;

    // Upper writedata bits are don't-care when WIDTH < 32.
    assign unused_wd = ^writedata;

    // Metastability synchroniser; stage 0 samples the raw pins.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in_port};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    generate
        if (DEBOUNCE_CYCLES > 0) begin : g_db
            localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
            logic [WIDTH-1:0] stable;

            for (genvar g = 0; g < WIDTH; g++) begin : g_ch
                logic [CNT_W-1:0] cnt;
                logic             st;

                // A change is accepted only after DEBOUNCE_CYCLES consecutive disagreeing samples.
                always_ff @(posedge clk or negedge reset_n) begin
                    if (!reset_n) begin
                        cnt <= '0;
                        st  <= 1'b0;
                    end else if (s[g] == st) begin
                        cnt <= '0;
                    end else if (cnt == CNT_LAST) begin
                        st  <= s[g];
                        cnt <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                assign stable[g] = st;
            end

            assign data_in = stable;
        end else begin : g_nodb
            assign data_in = s;
        end
    endgenerate

    always_comb begin
        edge_evt = data_in & ~prev;
        if (EDGE_TYPE == 1) begin
            edge_evt = ~data_in & prev;
        end else if (EDGE_TYPE == 2) begin
            edge_evt = data_in ^ prev;
        end
    end

    assign wr_en = chipselect & ~write_n;
    assign w1c   = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;

    // Bus registers; a new edge overrides a simultaneous W1C on the same bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev         <= '0;
            irq_mask     <= '0;
            edge_capture <= '0;
            readdata     <= '0;
        end else begin
            prev         <= data_in;
            edge_capture <= (edge_capture & ~w1c) | edge_evt;
            if (wr_en && address == ADDR_MASK) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            case (address)
                ADDR_DATA: readdata <= 32'(data_in);
                ADDR_MASK: readdata <= 32'(irq_mask);
                ADDR_EDGE: readdata <= 32'(edge_capture);
                default:   readdata <= '0;
            endcase
        end
    end

    assign irq = (IRQ_TYPE == 0) ? |(data_in & irq_mask) : |(edge_capture & irq_mask);

endmodule
